// File: rtl/mealy_11011_pkg.sv
// Shared types and constants for the 1-1-0-1-1 overlapping Mealy sequence detector.
package mealy_11011_pkg;

    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4
    } state_t;

    localparam logic [4:0]  SEQ     = 5'b11011;
    localparam int unsigned SEQ_LEN = 5;

endpackage

// File: rtl/match_counter.sv
// Wrapping match counter; cleared asynchronously, counts cycles where inc_i is high.
module match_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Natural modulo-2^CNT_W wrap from the fixed-width add.
    always_comb begin
        count_d = count_q;
        if (inc_i) begin
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/mealy_11011_overlap.sv
// Overlapping Mealy detector for serial pattern 1-1-0-1-1; d is combinational from state and n.
// Optional feature: define MATCH_COUNT_EN to add the CNT_W-bit match_count output.
module mealy_11011_overlap
    import mealy_11011_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             n,
`ifdef MATCH_COUNT_EN
    output logic [CNT_W-1:0] match_count,
`endif
    output logic             d
);

    state_t state_q;
    state_t state_d;
    logic   n_bit;

    // Unknown serial input is treated as 0 for both transitions and output.
    always_comb begin
        n_bit = 1'b0;
        if (n) begin
            n_bit = 1'b1;
        end
    end

    always_comb begin
        state_d = S0;
        d       = 1'b0;
        case (state_q)
            S0: state_d = n_bit ? S1 : S0;
            S1: state_d = n_bit ? S2 : S0;
            S2: state_d = n_bit ? S2 : S3;
            S3: state_d = n_bit ? S4 : S0;
            S4: begin
                // A match leaves the trailing "11" as progress for the next pattern.
                state_d = n_bit ? S2 : S0;
                d       = n_bit;
            end
            default: state_d = S0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S0;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef MATCH_COUNT_EN
    match_counter #(
        .CNT_W (CNT_W)
    ) u_match_counter (
        .clk_i   (clk),
        .rst_i   (rst),
        .inc_i   (d),
        .count_o (match_count)
    );
`endif

    cnt_w_legal_a: assert property (@(posedge clk) CNT_W >= 1);

endmodule

// File: tb/tb_mealy_11011_overlap.sv
// Directed bench for mealy_11011_overlap with an expected-d scoreboard queue.
module tb_mealy_11011_overlap;

    localparam int unsigned CW = 2;

    logic          clk;
    logic          rst;
    logic          n;
    logic          d;
    logic [CW-1:0] match_count;

    int unsigned   checks;
    int unsigned   errors;
    logic          exp_q[$];
    logic [CW-1:0] cnt_model;

    mealy_11011_overlap #(
        .CNT_W (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .n           (n),
`ifdef MATCH_COUNT_EN
        .match_count (match_count),
`endif
        .d           (d)
    );

`ifndef MATCH_COUNT_EN
    assign match_count = '0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_count(input string tag);
`ifdef MATCH_COUNT_EN
        checks++;
        assert (match_count === cnt_model) else begin
            errors++;
            $error("FAIL %s: observed count %0d expected %0d", tag, match_count, cnt_model);
        end
`endif
    endtask

    // Pop the oldest expected d and compare against the DUT.
    task automatic pop_check(input string tag);
        logic exp;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: observed empty scoreboard expected one entry", tag);
        end else begin
            exp = exp_q.pop_front();
            check_bit(tag, d, exp);
            if (exp) cnt_model = cnt_model + 1'b1;
        end
    endtask

    // Drive one serial bit mid-cycle, check d before the rising edge it is sampled on.
    task automatic step(input string tag, input logic b, input logic exp);
        @(negedge clk);
        check_count({tag, "_cnt"});
        n = b;
        exp_q.push_back(exp);
        #2;
        pop_check(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        n   = 1'b0;
        #1;
        check_bit("rst_d", d, 1'b0);
        cnt_model = '0;
        @(negedge clk);
        check_count("rst_cnt");
        rst = 1'b0;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        cnt_model = '0;
        n         = 1'b0;
        rst       = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_bit("reset_d", d, 1'b0);
        check_count("reset_cnt");
        @(negedge clk);
        rst = 1'b0;

        // Single match, then 0,1,1 from the S2 left behind.
        step("single1", 1'b1, 1'b0);
        step("single2", 1'b1, 1'b0);
        step("single3", 1'b0, 1'b0);
        step("single4", 1'b1, 1'b0);
        step("single5", 1'b1, 1'b1);
        step("post_s2_0", 1'b0, 1'b0);
        step("post_s2_1", 1'b1, 1'b0);
        step("post_s2_1b", 1'b1, 1'b1);

        // Overlap 11011011.
        do_reset();
        step("ovl1", 1'b1, 1'b0);
        step("ovl2", 1'b1, 1'b0);
        step("ovl3", 1'b0, 1'b0);
        step("ovl4", 1'b1, 1'b0);
        step("ovl5", 1'b1, 1'b1);
        step("ovl6", 1'b0, 1'b0);
        step("ovl7", 1'b1, 1'b0);
        step("ovl8", 1'b1, 1'b1);
        step("ovl_after", 1'b0, 1'b0);

        // Near misses: run of 1s holds S2; 00 returns to S0.
        do_reset();
        step("run1", 1'b1, 1'b0);
        step("run2", 1'b1, 1'b0);
        step("run3", 1'b1, 1'b0);
        step("run4", 1'b0, 1'b0);
        step("run5", 1'b1, 1'b0);
        step("run6", 1'b1, 1'b1);
        step("miss1", 1'b1, 1'b0);
        step("miss2", 1'b1, 1'b0);
        step("miss3", 1'b0, 1'b0);
        step("miss4", 1'b0, 1'b0);
        step("miss5", 1'b1, 1'b0);
        step("miss6", 1'b1, 1'b0);

        // Unknown n in S4 acts as 0: no match and back to S0.
        do_reset();
        step("x1", 1'b1, 1'b0);
        step("x2", 1'b1, 1'b0);
        step("x3", 1'b0, 1'b0);
        step("x4", 1'b1, 1'b0);
        step("x5", 1'bx, 1'b0);
        step("x6", 1'b1, 1'b0);
        step("x7", 1'b0, 1'b0);

        // Reset mid-pattern while sitting in S4 with n=1.
        do_reset();
        step("mid1", 1'b1, 1'b0);
        step("mid2", 1'b1, 1'b0);
        step("mid3", 1'b0, 1'b0);
        step("mid4", 1'b1, 1'b0);
        @(negedge clk);
        n = 1'b1;
        #1;
        check_bit("mid_pre_rst_d", d, 1'b1);
        rst = 1'b1;
        #1;
        check_bit("mid_rst_async_d", d, 1'b0);
        cnt_model = '0;
        @(negedge clk);
        check_count("mid_rst_cnt");
        rst = 1'b0;
        step("mid_after", 1'b1, 1'b0);
        step("mid_full1", 1'b1, 1'b0);
        step("mid_full2", 1'b1, 1'b0);
        step("mid_full3", 1'b0, 1'b0);
        step("mid_full4", 1'b1, 1'b0);
        step("mid_full5", 1'b1, 1'b1);

        // Five overlapping matches exercise the counter wrap (1,2,3,0,1 for CW=2).
        do_reset();
        step("wrap_a", 1'b1, 1'b0);
        step("wrap_b", 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step("wrap_0", 1'b0, 1'b0);
            step("wrap_1", 1'b1, 1'b0);
            step("wrap_m", 1'b1, 1'b1);
        end
        step("wrap_end", 1'b0, 1'b0);
`ifdef MATCH_COUNT_EN
        checks++;
        assert (match_count === 2'd1) else begin
            errors++;
            $error("FAIL wrap_final: observed count %0d expected 1", match_count);
        end
`endif

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_drain: observed %0d entries expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard time limit so the bench can never hang.
    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish before limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mealy_11011_overlap.md
Name: mealy_11011_overlap

Overview:
- Serial Mealy sequence detector for the 5-bit pattern 1-1-0-1-1, with overlapping matches allowed.
- Samples one serial bit per clock on n.
- Asserts d combinationally in the same cycle that the final bit of the pattern is present on n.
- Sits at the leaf of a serial-stream datapath as a pattern flag generator.

Parameters:
- CNT_W, default 8: width of the optional match counter. Unused unless MATCH_COUNT_EN is defined.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- n  input  1  serial data bit, sampled on rising clk
- d  output  1  Mealy match flag; combinational from state and n
- match_count  output  CNT_W  number of matches seen; port exists only with MATCH_COUNT_EN

Behaviour:
- Reset: rst high immediately forces state to S0, independent of clk. While rst is high, state stays S0 and d=0. match_count=0 when present.
- State encoding (3-bit register):
  - S0=0: no progress
  - S1=1: seen "1"
  - S2=2: seen "11"
  - S3=3: seen "110"
  - S4=4: seen "1101"
- Transitions on rising clk when rst is low, written as state: n=0 -> next / n=1 -> next:
  - S0: 0->S0, 1->S1
  - S1: 0->S0, 1->S2
  - S2: 0->S3, 1->S2 (a run of 1s keeps the "11" suffix)
  - S3: 0->S0, 1->S4
  - S4: 0->S0, 1->S2 (match; overlap keeps the trailing "11")
- Illegal codes 5..7 return to S0 on the next clock with d=0.
- Output: d = (state==S4) && (n==1). This is purely combinational, so there is zero-cycle latency from the final bit.
- d may glitch as n changes mid-cycle; consumers sample d on the rising clk.
- Overlap: "11011011" produces two matches, on bit 5 and bit 8.
- n equal to X or Z is treated as 0 for transitions and output.
- Reset mid-pattern discards all progress; a full 5-bit pattern is needed after reset deasserts.

Optional Feature:
- Macro: MATCH_COUNT_EN.
- Defined:
  - match_count is a CNT_W-bit register cleared asynchronously by rst.
  - It increments on every rising clk where d=1.
  - It wraps modulo 2^CNT_W.
  - It reads the new value one cycle after the match.
- Undefined: match_count port and its logic are absent; detection behaviour is identical.

Decomposition:
- Package mealy_11011_pkg holds:
  - state_t typedef (3-bit, S0..S4)
  - constant SEQ = 5'b11011
  - constant SEQ_LEN = 5
- The counter is a natural sub-module, match_counter, parameterized by CNT_W, instantiated only under MATCH_COUNT_EN.
- FSM next-state/output logic stays in the top module.

Test Plan:
- Reset: assert rst mid-cycle with n=1 in S4 -> state is S0 immediately, d=0 at once; with the option, match_count=0.
- Single match: after reset, n=1,1,0,1,1 on consecutive clocks -> d=0 for bits 1-4, d=1 during bit 5. The next state is S2.
- Overlap: n=1,1,0,1,1,0,1,1 -> d=1 during bits 5 and 8 only. With the option, match_count=2 after bit 8's clock.
- Near misses: n=1,1,1,0,1,1 -> d=1 on bit 6 (the run of 1s holds S2). Then n=1,1,0,0,1,1 -> no match (the 00 returns to S0).
- Reset mid-pattern: n=1,1,0,1, pulse rst, then n=1 -> d=0. A subsequent full 1,1,0,1,1 asserts d on its last bit.
- Counter wrap (MATCH_COUNT_EN, CNT_W=2): feed 5 overlapping matches (1,1 then 0,1,1 repeated five times) -> match_count sequence 1,2,3,0,1.
